// File: rtl/xge_pkt_gen_pkg.sv
// Shared definitions for the xge_pkt_gen frame generator: FSM encodings,
// default L2 header fields, minimum frame length and LFSR seed/taps.
package xge_pkt_gen_pkg;

  localparam logic [47:0] DEF_DST_MAC   = 48'h0010_9400_0002;
  localparam logic [47:0] DEF_SRC_MAC   = 48'h0010_9400_0001;
  localparam logic [15:0] DEF_ETHERTYPE = 16'h88B5;
  localparam int unsigned DEF_MIN_LEN   = 16;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SOP  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Fibonacci LFSR, polynomial x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/xge_lfsr32.sv
// 32-bit Fibonacci LFSR with synchronous seed load; supplies random frame
// lengths when xge_pkt_gen is built with XGE_PKT_GEN_RAND_LEN_EN.
module xge_lfsr32
  import xge_pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load_seed,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LFSR_SEED;
    end else if (load_seed) begin
      state <= LFSR_SEED;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/xge_pkt_gen.sv
// Back-to-back Ethernet frame generator feeding the xge_mac pkt_tx_* FIFO port.
// Build option XGE_PKT_GEN_RAND_LEN_EN: per-frame random length from an LFSR.
module xge_pkt_gen
  import xge_pkt_gen_pkg::*;
#(
  parameter logic [47:0] DST_MAC   = DEF_DST_MAC,
  parameter logic [47:0] SRC_MAC   = DEF_SRC_MAC,
  parameter logic [15:0] ETHERTYPE = DEF_ETHERTYPE,
  parameter int unsigned MIN_LEN   = DEF_MIN_LEN
) (
  input  logic        clk_156m25,
  input  logic        reset_156m25_n,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [15:0] cfg_num_pkts,
  input  logic [13:0] cfg_pkt_len,
  input  logic [7:0]  cfg_ipg,
  output logic        gen_busy,
  output logic        gen_done,
  output logic [15:0] gen_pkt_cnt,
  input  logic        pkt_tx_full,
  output logic        pkt_tx_val,
  output logic        pkt_tx_sop,
  output logic        pkt_tx_eop,
  output logic [2:0]  pkt_tx_mod,
  output logic [63:0] pkt_tx_data
);

  logic [2:0]  state;
  logic [13:0] len_q;
  logic [13:0] word_idx;
  logic [13:0] last_idx;
  logic [15:0] seq;
  logic [7:0]  gap_cnt;
  logic        stop_pending;
  logic [13:0] len_sel;
  logic [15:0] cnt_next;

  function automatic logic [7:0] frame_byte(input logic [16:0] k, input logic [13:0] len,
                                            input logic [15:0] seq_v);
    logic [111:0] hdr;
    logic [7:0]   b;
    hdr = {DST_MAC, SRC_MAC, ETHERTYPE} << (8 * k);
    if (k >= {3'b000, len})  b = 8'h00;
    else if (k < 17'd14)     b = hdr[111:104];
    else if (k == 17'd14)    b = seq_v[15:8];
    else if (k == 17'd15)    b = seq_v[7:0];
    else                     b = 8'(k - 17'd16);
    return b;
  endfunction

  // First byte on the wire lands in [63:56]
  function automatic logic [63:0] build_word(input logic [13:0] idx, input logic [13:0] len,
                                             input logic [15:0] seq_v);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 8; i++)
      w = {w[55:0], frame_byte({idx, 3'(i)}, len, seq_v)};
    return w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [2:0] after_frame(input logic [15:0] cnt, input logic stop,
                                             input logic [15:0] num);
    if (stop || (num != 16'd0 && cnt == num)) return ST_DONE;
    return ST_SOP;
  endfunction

`ifdef XGE_PKT_GEN_RAND_LEN_EN
  logic        sop_accept;
  logic        start_accept;
  logic [31:0] lfsr_state;
  logic [13:0] span;

  assign sop_accept   = (state == ST_SOP) && !pkt_tx_full;
  assign start_accept = (state == ST_IDLE) && cfg_start;

  xge_lfsr32 u_lfsr (
    .clk       (clk_156m25),
    .rst_n     (reset_156m25_n),
    .enable    (sop_accept),
    .load_seed (start_accept),
    .state     (lfsr_state)
  );

  always_comb begin
    span    = 14'd1;
    len_sel = 14'(MIN_LEN);
    if (cfg_pkt_len > 14'(MIN_LEN)) begin
      span    = cfg_pkt_len - 14'(MIN_LEN) + 14'd1;
      len_sel = 14'(MIN_LEN) + (lfsr_state[13:0] % span);
    end
  end
`else
  assign len_sel = (cfg_pkt_len < 14'(MIN_LEN)) ? 14'(MIN_LEN) : cfg_pkt_len;
`endif

  assign cnt_next = sat_inc16(gen_pkt_cnt);

  // ---- output stage: every pkt_tx_* and status output is a register ----
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state        <= ST_IDLE;
      len_q        <= '0;
      word_idx     <= '0;
      last_idx     <= '0;
      seq          <= '0;
      gap_cnt      <= '0;
      stop_pending <= 1'b0;
      gen_busy     <= 1'b0;
      gen_done     <= 1'b0;
      gen_pkt_cnt  <= '0;
      pkt_tx_val   <= 1'b0;
      pkt_tx_sop   <= 1'b0;
      pkt_tx_eop   <= 1'b0;
      pkt_tx_mod   <= '0;
      pkt_tx_data  <= '0;
    end else begin
      pkt_tx_val <= 1'b0;
      pkt_tx_sop <= 1'b0;
      pkt_tx_eop <= 1'b0;
      pkt_tx_mod <= '0;
      gen_done   <= 1'b0;

      if (cfg_stop && state != ST_IDLE) stop_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          // Start wins over a coincident stop
          if (cfg_start) begin
            state        <= ST_SOP;
            gen_pkt_cnt  <= '0;
            seq          <= '0;
            gen_busy     <= 1'b1;
            stop_pending <= 1'b0;
          end
        end
        ST_SOP: begin
          if (!pkt_tx_full) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_sop  <= 1'b1;
            pkt_tx_data <= build_word(14'd0, len_sel, seq);
            len_q       <= len_sel;
            last_idx    <= (len_sel - 14'd1) >> 3;
            word_idx    <= 14'd1;
            state       <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (!pkt_tx_full) begin
            pkt_tx_val  <= 1'b1;
            pkt_tx_data <= build_word(word_idx, len_q, seq);
            word_idx    <= word_idx + 14'd1;
            if (word_idx == last_idx) begin
              pkt_tx_eop  <= 1'b1;
              pkt_tx_mod  <= len_q[2:0];
              gen_pkt_cnt <= cnt_next;
              seq         <= seq + 16'd1;
              // A zero gap decides the next frame right at EOP
              if (cfg_ipg == 8'd0) begin
                state <= after_frame(cnt_next, stop_pending | cfg_stop, cfg_num_pkts);
              end else begin
                gap_cnt <= cfg_ipg;
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - 8'd1;
          if (gap_cnt <= 8'd1)
            state <= after_frame(gen_pkt_cnt, stop_pending | cfg_stop, cfg_num_pkts);
        end
        ST_DONE: begin
          gen_done     <= 1'b1;
          gen_busy     <= 1'b0;
          stop_pending <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xge_pkt_gen.sv
// Randomized self-checking bench for xge_pkt_gen against a byte-level frame model.
module tb_xge_pkt_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_stop = 1'b0;
  logic [15:0] cfg_num_pkts = '0;
  logic [13:0] cfg_pkt_len = '0;
  logic [7:0]  cfg_ipg = '0;
  logic        gen_busy, gen_done;
  logic [15:0] gen_pkt_cnt;
  logic        pkt_tx_full = 1'b0;
  logic        pkt_tx_val, pkt_tx_sop, pkt_tx_eop;
  logic [2:0]  pkt_tx_mod;
  logic [63:0] pkt_tx_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int bp_pct  = 0;
  int hold_full = 0;
  logic full_at_edge = 1'b0;

  logic [63:0] obs_data[$];
  logic        obs_sop[$];
  logic        obs_eop[$];
  logic [2:0]  obs_mod[$];
  int          sop_cyc[$];
  int          eop_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  xge_pkt_gen dut (
    .clk_156m25     (clk),
    .reset_156m25_n (rst_n),
    .cfg_start      (cfg_start),
    .cfg_stop       (cfg_stop),
    .cfg_num_pkts   (cfg_num_pkts),
    .cfg_pkt_len    (cfg_pkt_len),
    .cfg_ipg        (cfg_ipg),
    .gen_busy       (gen_busy),
    .gen_done       (gen_done),
    .gen_pkt_cnt    (gen_pkt_cnt),
    .pkt_tx_full    (pkt_tx_full),
    .pkt_tx_val     (pkt_tx_val),
    .pkt_tx_sop     (pkt_tx_sop),
    .pkt_tx_eop     (pkt_tx_eop),
    .pkt_tx_mod     (pkt_tx_mod),
    .pkt_tx_data    (pkt_tx_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference frame byte k of frame number f
  function automatic logic [7:0] ref_byte(input int k, input int f);
    logic [111:0] hdr;
    hdr = 112'h0010_9400_0002_0010_9400_0001_88B5;
    if (k < 14)  return hdr[111 - 8*k -: 8];
    if (k == 14) return 8'((f >> 8) & 255);
    if (k == 15) return 8'(f & 255);
    return 8'((k - 16) % 256);
  endfunction

  // Backpressure driver
  initial forever begin
    @(negedge clk);
    if (hold_full > 0) begin
      pkt_tx_full = 1'b1;
      hold_full--;
    end else begin
      pkt_tx_full = (bp_pct > 0) && ($urandom_range(0, 99) < bp_pct);
    end
  end

  initial forever begin
    @(posedge clk);
    full_at_edge = pkt_tx_full;
  end

  // Output monitor
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      if (pkt_tx_val) begin
        obs_data.push_back(pkt_tx_data);
        obs_sop.push_back(pkt_tx_sop);
        obs_eop.push_back(pkt_tx_eop);
        obs_mod.push_back(pkt_tx_mod);
        if (pkt_tx_sop) sop_cyc.push_back(cyc);
        if (pkt_tx_eop) eop_cyc.push_back(cyc);
        check_eq("sop_eop_excl", 64'(pkt_tx_sop & pkt_tx_eop), 64'd0);
      end else begin
        check_eq("idle_flags", 64'({pkt_tx_sop, pkt_tx_eop}), 64'd0);
      end
      if (full_at_edge) check_eq("full_stall", 64'(pkt_tx_val), 64'd0);
      if (gen_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_case(input string name, input int num, input int len, input int ipg,
                          input int bp, input int stop_at, input bit same_stop,
                          input int hold_at, input bit spur);
    logic [63:0] ed[$];
    logic        es[$];
    logic        ee[$];
    logic [2:0]  em[$];
    logic [63:0] word;
    int n_exp, waited, le, nw, k;
    bit held;
    obs_data.delete(); obs_sop.delete(); obs_eop.delete(); obs_mod.delete();
    sop_cyc.delete(); eop_cyc.delete();
    done_cnt = 0;
    cfg_num_pkts = 16'(num);
    cfg_pkt_len  = 14'(len);
    cfg_ipg      = 8'(ipg);
    bp_pct       = bp;
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_stop  = same_stop;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_stop  = 1'b0;
    check_eq({name, "_busy"}, 64'(gen_busy), 64'd1);
    n_exp = num;
    if (stop_at > 0) begin
      repeat (stop_at) @(negedge clk);
      cfg_stop = 1'b1;
      @(negedge clk);
      cfg_stop = 1'b0;
      #1;
      n_exp = sop_cyc.size();
    end
    waited = 0;
    held = 1'b0;
    while (done_cnt == 0 && waited < 5000) begin
      @(negedge clk);
      waited++;
      cfg_start = spur && (waited == 2);
      if (hold_at > 0 && !held && obs_data.size() >= hold_at) begin
        hold_full = 5;
        held = 1'b1;
      end
    end
    cfg_start = 1'b0;
    bp_pct = 0;
    repeat (6) @(negedge clk);
    check_eq({name, "_done_once"}, 64'(done_cnt), 64'd1);
    check_eq({name, "_busy_end"}, 64'(gen_busy), 64'd0);
    check_eq({name, "_pkt_cnt"}, 64'(gen_pkt_cnt), 64'(n_exp));

    le = (len < 16) ? 16 : len;
    nw = (le + 7) / 8;
    for (int f = 0; f < n_exp; f++) begin
      for (int w = 0; w < nw; w++) begin
        word = '0;
        for (int b = 0; b < 8; b++) begin
          k = 8*w + b;
          word = {word[55:0], (k < le) ? ref_byte(k, f) : 8'h00};
        end
        ed.push_back(word);
        es.push_back(w == 0);
        ee.push_back(w == nw - 1);
        em.push_back((w == nw - 1) ? 3'(le % 8) : 3'd0);
      end
    end
    check_eq({name, "_nwords"}, 64'(obs_data.size()), 64'(ed.size()));
    for (int i = 0; i < ed.size(); i++) begin
      if (i < obs_data.size()) begin
        check_eq({name, "_data"}, obs_data[i], ed[i]);
        check_eq({name, "_sop"}, 64'(obs_sop[i]), 64'(es[i]));
        check_eq({name, "_eop"}, 64'(obs_eop[i]), 64'(ee[i]));
        check_eq({name, "_mod"}, 64'(obs_mod[i]), 64'(em[i]));
      end
    end
    if (bp == 0 && hold_at == 0) begin
      for (int i = 1; i < sop_cyc.size(); i++)
        if (i - 1 < eop_cyc.size())
          check_eq({name, "_ipg"}, 64'(sop_cyc[i] - eop_cyc[i-1] - 1), 64'(ipg));
      if (eop_cyc.size() > 0)
        check_eq({name, "_done_lat"}, 64'(done_cyc - eop_cyc[eop_cyc.size()-1]), 64'(ipg + 1));
    end
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    check_eq("rst_val", 64'(pkt_tx_val), 64'd0);
    check_eq("rst_data", pkt_tx_data, 64'd0);
    check_eq("rst_busy", 64'(gen_busy), 64'd0);
    check_eq("rst_cnt", 64'(gen_pkt_cnt), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 64-byte frame, header words checked against literal values
    run_case("t1", 1, 64, 0, 0, 0, 1'b0, 0, 1'b0);
    check_eq("t1_word0", obs_data[0], 64'h0010_9400_0002_0010);
    check_eq("t1_word1", obs_data[1], 64'h9400_0001_88B5_0000);

    run_case("t2", 3, 61, 0, 0, 0, 1'b0, 0, 1'b0);
    check_eq("t2_mod", 64'(obs_mod[7]), 64'd5);

    run_case("t3_hold", 1, 100, 0, 0, 0, 1'b0, 4, 1'b0);
    run_case("t4_stop", 0, 40, 2, 0, $urandom_range(20, 60), 1'b0, 0, 1'b0);
    run_case("t5_clamp", 3, 5, 3, 0, 0, 1'b0, 0, 1'b0);
    run_case("t_startstop", 2, 20, 1, 0, 0, 1'b1, 0, 1'b0);

    for (int it = 0; it < 10; it++) begin
      int num, len, ipg, bp;
      num = $urandom_range(1, 4);
      len = $urandom_range(1, 300);
      ipg = $urandom_range(0, 5);
      bp  = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 60) : 0;
      run_case("rnd", num, len, ipg, bp, 0, 1'b0, 0, num >= 2);
    end

    // Reset in the middle of a frame
    cfg_num_pkts = 16'd1;
    cfg_pkt_len  = 14'd200;
    cfg_ipg      = 8'd0;
    obs_data.delete();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    waited = 0;
    while (obs_data.size() < 5 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check_eq("t6_in_data", 64'(obs_data.size() >= 5), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_val", 64'(pkt_tx_val), 64'd0);
    check_eq("t6_flags", 64'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}), 64'd0);
    check_eq("t6_data", pkt_tx_data, 64'd0);
    check_eq("t6_status", 64'({gen_busy, gen_done}), 64'd0);
    check_eq("t6_cnt", 64'(gen_pkt_cnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_case("t6_after", 2, 64, 1, 0, 0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
